// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD    = 2'd1,
      FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder from two half-adder stages and an OR; purely combinational.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic h1_s;
   logic h1_c;
   logic h2_c;

   assign h1_s = a ^ b;
   assign h1_c = a & b;
   assign s    = h1_s ^ cin;
   assign h2_c = h1_s & cin;
   assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first through one full-adder cell; done WIDTH+1 cycles after start.
// No backpressure: start is taken only in IDLE/FINISH and ignored while busy.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] TERM = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] ws;
   logic [WIDTH-1:0] ws_nxt;
   logic             cf;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;

   full_adder u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (cf),
      .s    (fa_s),
      .cout (fa_c)
   );

   // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
   assign ws_nxt = {fa_s, ws[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sa    <= '0;
         sb    <= '0;
         ws    <= '0;
         cf    <= 1'b0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  cf    <= 1'b0;
                  ws    <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ADD;
               end else begin
                  state <= IDLE;
               end
            end
            ADD: begin
               sa <= sa >> 1;
               sb <= sb >> 1;
               cf <= fa_c;
               ws <= ws_nxt;
               if (cnt == TERM) begin
                  sum   <= ws_nxt;
                  carry <= fa_c;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder, the addition counterpart of the team's subtractor cells. It accepts two WIDTH-bit operands on a start pulse and adds them LSB-first, one bit per clock, through a single full-adder cell. It returns a WIDTH-bit sum plus carry-out with a one-cycle done pulse. It is intended for area-constrained datapaths where one adder bit-slice is reused instead of a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range ≥ 2.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/carry are updated.
- sum  output  WIDTH  (a + b) mod 2^WIDTH of the last completed operation.
- carry  output  1  carry-out of bit WIDTH-1 of the last completed operation.

## Operation
- States: IDLE, ADD, FINISH.
- IDLE: busy=0. If start=1, do the following and go to ADD:
  - load shift registers sa←a and sb←b;
  - clear the internal carry flop;
  - clear the working sum register;
  - clear the bit counter.
- ADD: busy=1. Each cycle:
  - full-add sa[0], sb[0] and the carry flop;
  - shift the result bit into the MSB of the working sum register, shifting right;
  - shift sa and sb right by one;
  - latch the new carry;
  - increment the counter.
  - After the WIDTH-th bit, go to FINISH.
- FINISH: busy=0, done=1 for this single cycle. sum←working register and carry←carry flop are loaded on the transition into FINISH, so they are valid while done=1. Next state is IDLE. A start in FINISH is accepted exactly as in IDLE.
- sum/carry hold their value from the previous result until the next FINISH. They never show partial results.
- start while busy=1 is ignored. a/b changes while busy have no effect.
- Arithmetic: unsigned. Carry-in is always 0. {carry,sum} equals the exact (WIDTH+1)-bit sum.
- rst=1: synchronous return to IDLE from any state, including mid-ADD; any in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, sum=0, carry=0, state=IDLE, counter=0.
- Start accepted at edge T. busy=1 for cycles T+1 … T+WIDTH. done=1 in cycle T+WIDTH+1.
- Latency from accepted start to done is WIDTH+1 cycles.
- Throughput: one operation per WIDTH+1 cycles with back-to-back starts, where start is held or re-asserted during FINISH.
- Counter width is $clog2(WIDTH)+1. Terminal count is WIDTH-1, with no wrap-around beyond it.
- rst and start both high: rst wins. rst asserted in the done cycle clears done on the next edge.

## Structure
- Shared package serial_adder_pkg:
  - state enum {IDLE, ADD, FINISH};
  - default WIDTH constant.
- One sub-module, full_adder. Inputs a, b, cin; outputs s, cout. It is built from two half-adder cells plus an OR, reusing the team's half-cell style.
- Top level contains the FSM, shift registers, counter and output registers.

## Test plan
- Reset then idle, WIDTH=8: after rst, sum=0, carry=0, busy=0, done=0. All stay 0 for 20 cycles with start=0.
- a=100, b=27, start pulse at edge T: busy high T+1..T+8; done high only at T+9; sum=127, carry=0.
- a=255, b=1: sum=0, carry=1. Then a=255, b=255: sum=254, carry=1.
- Start re-pulsed with a=0, b=0 during busy of a 5+3 operation: the second request is ignored; result is sum=8; done pulses once.
- rst for one cycle at T+4 of a 200+100 operation: next cycle busy=0, sum=0, carry=0, and no done pulse follows. A new 1+2 operation then yields sum=3.
- start held high continuously with a=10, b=20: done every 9 cycles, sum=30 each time. sum stays 30 between pulses and never shows intermediate values.
